mem_lsu: RTL
============

# mem_lsu

Load/store unit between the pipeline memory stage and the byte-addressed 64-byte data memory. It accepts one load or store request at a time over a valid/ready handshake. It checks the access and translates RISC-V funct3 into the memory's access-type code, then sequences address, data and write-enable to the memory through a small FSM. It returns load data or a store completion, with an error code, over a valid/ready response channel.

## Interface
Parameters:
- WAIT_CYCLES, 1: settle cycles between driving address/type and writing or capturing; legal 0..15.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response present; held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
- dm_wr  out  1  memory write enable
- dm_addr  out  6  memory byte address
- dm_din  out  32  memory write data
- dm_type  out  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
- dm_dout  in  32  memory read data, already sign/zero extended by the memory

## Operation
- FSM states: IDLE, SETUP, WAIT, XFER, RESP.
- IDLE: req_ready=1. When req_valid && req_ready, latch the request and compute the access size: 1 for b/bu, 2 for h/hu, 4 for w.
- Check priority, highest first:
  - illegal funct3 gives 11: loads 011/110/111; stores any funct3 other than 000/001/010.
  - out of range gives 10: addr[31:6]!=0, or addr[5:0]+size-1 > 63 computed in 7 bits.
  - misaligned gives 01: only under the macro in Configuration.
- Error path: IDLE to RESP directly. The memory is never touched and dm_wr stays 0.
- Good path: IDLE to SETUP.
- SETUP: drive dm_addr=addr[5:0], dm_type, and dm_din=wdata for stores. dm_wr=0. Go to WAIT if WAIT_CYCLES>0, else to XFER.
- WAIT: count WAIT_CYCLES cycles with dm_* held, then go to XFER.
- XFER:
  - Store: dm_wr=1 for exactly one cycle, with dm_addr/dm_din/dm_type unchanged.
  - Load: register rsp_rdata <= dm_dout.
  - Then go to RESP.
- RESP: rsp_valid=1 with rsp_rdata and rsp_err stable. On rsp_ready, go to IDLE, clear rsp_valid, and return dm_* to idle values (addr 0, din 0, type 000).
- funct3 to dm_type mapping: 000→011, 001→001, 010→000, 100→100, 101→010.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, dm_wr=0, dm_addr=0, dm_din=0, dm_type=000; state IDLE.
- Good access latency, with acceptance edge = cycle 0:
  - SETUP in cycle 1.
  - WAIT in cycles 2..1+WAIT_CYCLES.
  - XFER in cycle 2+WAIT_CYCLES.
  - rsp_valid first high in cycle 3+WAIT_CYCLES.
  - With WAIT_CYCLES=1, rsp_valid first rises in cycle 4.
- Error latency: rsp_valid high in cycle 1.
- Back-to-back: if rsp_ready=1 in the first RESP cycle, req_ready is high the next cycle. There is no same-cycle accept in RESP.
- Response backpressure: RESP holds indefinitely. No new request is accepted while rsp_valid=1.
- dm_wr is never high outside XFER. Address, data and type are stable for at least one cycle before and during the write.
- Reset mid-operation: all outputs go to reset values asynchronously, and any dm_wr pulse is cut. An aborted store may or may not have been written; the pipeline reissues it.
- Request inputs are sampled only at acceptance. Later changes to them are ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - halfword with addr[0]!=0 gives rsp_err=01;
  - word with addr[1:0]!=0 gives rsp_err=01;
  - the memory is not accessed.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned accesses go to the byte-addressed memory unchanged;
  - code 01 is never produced;
  - range and illegal checks are unchanged.

## Test plan
- Reset released, then `sw` to 0x10 with 0xDEADBEEF -> exactly one dm_wr pulse with dm_addr=0x10 and dm_type=000; rsp_valid in cycle 4, rsp_err=00, rsp_rdata=0.
- After that store, `lb` at 0x13 (memory returns 0xFFFFFFDE) -> dm_type=011; rsp_rdata=0xFFFFFFDE, err 00. Then `lhu` at 0x12 (memory returns 0x0000DEAD) -> dm_type=010; rsp_rdata=0x0000DEAD.
- `lw` at 0x3E -> rsp_err=10 in cycle 1, no dm_wr, rsp_rdata=0. `sb` at 0x40 -> rsp_err=10.
- Store with funct3=100 -> rsp_err=11. Load with funct3=011 at 0x1 -> rsp_err=11, because illegal has priority over other errors.
- `lh` at 0x05 -> rsp_err=01 with the macro defined; rsp_err=00 and a normal read without it.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. Separately, deassert rstn during XFER of a store -> dm_wr=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Bundle of the LSU request/response channels and the data-memory port.
// The slave modport is the LSU's view; the master modport is the environment (pipeline plus memory).
interface mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        dm_wr;
   logic [5:0]  dm_addr;
   logic [31:0] dm_din;
   logic [2:0]  dm_type;
   logic [31:0] dm_dout;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dm_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_wr, dm_addr, dm_din, dm_type
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dm_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_wr, dm_addr, dm_din, dm_type
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit sequencing one request at a time into a 64-byte data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (traps misaligned half/word accesses with error 01).
module mem_lsu #(
   parameter int WAIT_CYCLES = 1
) (
   input logic      clk,
   input logic      rstn,
   mem_lsu_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_WAIT  = 3'd2,
      S_XFER  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic       HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [3:0] WAIT_LD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic [1:0]  r_rsp_err;
   logic        r_dm_wr;
   logic [5:0]  r_dm_addr;
   logic [31:0] r_dm_din;
   logic [2:0]  r_dm_type;
   logic        r_we;
   logic [3:0]  r_cnt;

   logic [2:0]  w_size;
   logic [6:0]  w_end;
   logic        w_illegal;
   logic        w_range;
   logic        w_misalign;
   logic [1:0]  w_err;

   // Access size in bytes; funct3[1:0] selects b/h/w for both signed and unsigned forms.
   function automatic logic [2:0] f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   f3_size = 3'd1;
         2'b01:   f3_size = 3'd2;
         2'b10:   f3_size = 3'd4;
         default: f3_size = 3'd1;
      endcase
   endfunction

   function automatic logic [2:0] f3_type(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_type = 3'b011;
         3'b001:  f3_type = 3'b001;
         3'b010:  f3_type = 3'b000;
         3'b100:  f3_type = 3'b100;
         3'b101:  f3_type = 3'b010;
         default: f3_type = 3'b000;
      endcase
   endfunction

   // Request classification, evaluated on the live request inputs while idle.
   always_comb begin
      w_size    = f3_size(bus.req_funct3);
      w_end     = {1'b0, bus.req_addr[5:0]} + {4'b0000, w_size} - 7'd1;
      w_illegal = 1'b0;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
         3'b100, 3'b101:         w_illegal = bus.req_we;
         default:                w_illegal = 1'b1;
      endcase
      w_range = (bus.req_addr[31:6] != 26'd0) || (w_end > 7'd63);
`ifdef LSU_MISALIGN_TRAP_EN
      w_misalign = ((w_size == 3'd2) && bus.req_addr[0]) ||
                   ((w_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
      w_misalign = 1'b0;
`endif
      if (w_illegal) begin
         w_err = 2'b11;
      end else if (w_range) begin
         w_err = 2'b10;
      end else if (w_misalign) begin
         w_err = 2'b01;
      end else begin
         w_err = 2'b00;
      end
   end

   // Control FSM; every output is a register updated on the transition into the state that shows it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 2'b00;
         r_dm_wr     <= 1'b0;
         r_dm_addr   <= 6'd0;
         r_dm_din    <= 32'd0;
         r_dm_type   <= 3'b000;
         r_we        <= 1'b0;
         r_cnt       <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_we        <= bus.req_we;
                  r_rsp_rdata <= 32'd0;
                  r_rsp_err   <= w_err;
                  if (w_err != 2'b00) begin
                     // Rejected requests bypass the memory entirely.
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     r_dm_addr <= bus.req_addr[5:0];
                     r_dm_type <= f3_type(bus.req_funct3);
                     r_dm_din  <= bus.req_we ? bus.req_wdata : 32'd0;
                     r_state   <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               if (HAS_WAIT) begin
                  r_cnt   <= WAIT_LD;
                  r_state <= S_WAIT;
               end else begin
                  r_dm_wr <= r_we;
                  r_state <= S_XFER;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_dm_wr <= r_we;
                  r_state <= S_XFER;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_XFER: begin
               r_dm_wr     <= 1'b0;
               r_rsp_valid <= 1'b1;
               if (!r_we) begin
                  r_rsp_rdata <= bus.dm_dout;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_dm_addr   <= 6'd0;
                  r_dm_din    <= 32'd0;
                  r_dm_type   <= 3'b000;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_dm_wr     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.dm_wr     = r_dm_wr;
   assign bus.dm_addr   = r_dm_addr;
   assign bus.dm_din    = r_dm_din;
   assign bus.dm_type   = r_dm_type;

endmodule
